// File: rtl/apb_regbus_pkg.sv
// Shared types and constants for the APB to register-bus bridge.
package apb_regbus_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    // Low address bits that must be zero for a word-aligned access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        DONE
    } state_e;

endpackage

// File: rtl/regbus_timeout_cnt.sv
// Read-wait watchdog for the bridge.
// Only active when BRIDGE_TIMEOUT_EN is defined; otherwise expired is tied low
// and no counter state exists.
module regbus_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count enabled cycles, saturating at the limit; clear dominates.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    // True during the TIMEOUT_CYCLES-th enabled cycle, so the owner leaves at that edge.
    assign expired = enable && (count == LAST);
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_inputs;

    assign unused_inputs = clk ^ rst ^ clear ^ enable;
    assign expired       = 1'b0;
`endif

endmodule

// File: rtl/apb_regbus_bridge.sv
// APB3 slave to register-bus master bridge.
// One APB transfer becomes exactly one register-bus access. Misaligned
// addresses are rejected without touching the bus. Define BRIDGE_TIMEOUT_EN
// to abort reads that never see data_valid after TIMEOUT_CYCLES RD cycles.
module apb_regbus_bridge
    import apb_regbus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // APB slave side
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    // Register-bus master side
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  chip_select,
    output logic                  write_en,
    output logic                  read_en,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  data_valid
);

    state_e state;
    logic   err;
    logic   cnt_clear;
    logic   cnt_enable;
    logic   timeout_hit;

    assign cnt_enable = (state == RD);
    assign cnt_clear  = (state != RD);

    regbus_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expired(timeout_hit)
    );

    // Transfer FSM; every APB and bus output is a flop updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            err         <= 1'b0;
            addr        <= '0;
            write_data  <= '0;
            prdata      <= '0;
            chip_select <= 1'b0;
            write_en    <= 1'b0;
            read_en     <= 1'b0;
            pready      <= 1'b0;
            pslverr     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    err     <= 1'b0;
                    // Only a setup phase starts a transfer; a stale access phase is ignored.
                    if (psel && !penable) begin
                        addr       <= paddr;
                        write_data <= pwdata;
                        if ((paddr[1:0] & ALIGN_MASK) != 2'b00) begin
                            err     <= 1'b1;
                            state   <= DONE;
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                        end else if (pwrite) begin
                            state       <= WR;
                            chip_select <= 1'b1;
                            write_en    <= 1'b1;
                        end else begin
                            state       <= RD;
                            chip_select <= 1'b1;
                            read_en     <= 1'b1;
                        end
                    end
                end
                WR: begin
                    state       <= DONE;
                    chip_select <= 1'b0;
                    write_en    <= 1'b0;
                    pready      <= 1'b1;
                    pslverr     <= err;
                end
                RD: begin
                    // data_valid wins over a coincident timeout.
                    if (data_valid) begin
                        prdata      <= read_data;
                        state       <= DONE;
                        chip_select <= 1'b0;
                        read_en     <= 1'b0;
                        pready      <= 1'b1;
                        pslverr     <= err;
                    end else if (timeout_hit) begin
                        prdata      <= '0;
                        err         <= 1'b1;
                        state       <= DONE;
                        chip_select <= 1'b0;
                        read_en     <= 1'b0;
                        pready      <= 1'b1;
                        pslverr     <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    err     <= 1'b0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_regbus_bridge.sv
// Directed, table-driven bench for apb_regbus_bridge with a small register-file model.
module tb_apb_regbus_bridge;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [7:0]  addr;
    logic        chip_select;
    logic        write_en;
    logic        read_en;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        data_valid;

    apb_regbus_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr),
        .addr       (addr),
        .chip_select(chip_select),
        .write_en   (write_en),
        .read_en    (read_en),
        .write_data (write_data),
        .read_data  (read_data),
        .data_valid (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: registered one-cycle data_valid pulse per read strobe.
    logic [31:0] mem [64];
    logic        dv_q;
    logic        dv_block;

    always @(posedge clk) begin
        if (rst) begin
            dv_q <= 1'b0;
        end else begin
            if (chip_select && write_en) mem[addr[7:2]] <= write_data;
            dv_q <= chip_select && read_en && !dv_q && !dv_block;
        end
    end

    assign data_valid = dv_q;
    assign read_data  = (chip_select && read_en) ? mem[addr[7:2]] : 32'h0;

    // Bus monitor: per-cycle strobe counts and protocol sanity.
    int          cs_cnt = 0;
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          bad_strobe = 0;
    logic [7:0]  last_wr_addr = 8'h0;
    logic [31:0] last_wr_data = 32'h0;

    always @(negedge clk) begin
        if (chip_select) cs_cnt++;
        if (write_en) begin
            we_cnt++;
            last_wr_addr = addr;
            last_wr_data = write_data;
        end
        if (read_en) re_cnt++;
        if (write_en && read_en) bad_strobe++;
        if ((write_en || read_en) && !chip_select) bad_strobe++;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Called just after a posedge. Drives setup now, access phase after the
    // next edge; lat counts cycles from the setup edge to the pready cycle (-1 on timeout).
    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            input int budget, output int lat, output logic err,
                            output logic [31:0] rd, output int cs_n, output int we_n,
                            output int re_n);
        int cs0, we0, re0;
        cs0 = cs_cnt; we0 = we_cnt; re0 = re_cnt;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = -1; err = 1'b0; rd = 32'h0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (pready) begin
                lat = n;
                err = pslverr;
                rd  = prdata;
                break;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        cs_n = cs_cnt - cs0; we_n = we_cnt - we0; re_n = re_cnt - re0;
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        int          lat;
        logic        err;
        logic [31:0] rd;
        int          cs;
        int          we;
        int          re;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          lat, cs_n, we_n, re_n;
        logic        err;
        logic [31:0] rd;

        //              wr    addr   wdata         lat err   prdata        cs we re
        vecs[0] = '{1'b1, 8'h10, 32'h00000001, 2, 1'b0, 32'h00000000, 1, 1, 0};
        vecs[1] = '{1'b1, 8'h14, 32'hDEADBEEF, 2, 1'b0, 32'h00000000, 1, 1, 0};
        vecs[2] = '{1'b0, 8'h14, 32'h0,        3, 1'b0, 32'hDEADBEEF, 2, 0, 2};
        vecs[3] = '{1'b1, 8'h13, 32'h55555555, 1, 1'b1, 32'hDEADBEEF, 0, 0, 0};
        vecs[4] = '{1'b0, 8'h16, 32'h0,        1, 1'b1, 32'hDEADBEEF, 0, 0, 0};
        vecs[5] = '{1'b0, 8'h14, 32'h0,        3, 1'b0, 32'hDEADBEEF, 2, 0, 2};
        vecs[6] = '{1'b0, 8'h10, 32'h0,        3, 1'b0, 32'h00000001, 2, 0, 2};
        vecs[7] = '{1'b1, 8'h3C, 32'h12345678, 2, 1'b0, 32'h00000001, 1, 1, 0};
        vecs[8] = '{1'b0, 8'h3C, 32'h0,        3, 1'b0, 32'h12345678, 2, 0, 2};
        vecs[9] = '{1'b0, 8'h01, 32'h0,        1, 1'b1, 32'h12345678, 0, 0, 0};

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h0; pwdata = 32'h0; dv_block = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_pready", {31'h0, pready}, 32'h0);
        check("rst_pslverr", {31'h0, pslverr}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_strobes", {29'h0, chip_select, write_en, read_en}, 32'h0);
        check("rst_addr", {24'h0, addr}, 32'h0);
        check("rst_wdata", write_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of single transfers with an idle cycle between them
        for (int i = 0; i < 10; i++) begin
            apb_xfer(vecs[i].wr, vecs[i].a, vecs[i].d, 40, lat, err, rd, cs_n, we_n, re_n);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_pslverr", i), {31'h0, err}, {31'h0, vecs[i].err});
            check($sformatf("v%0d_prdata", i), rd, vecs[i].rd);
            check($sformatf("v%0d_cs_cycles", i), cs_n, vecs[i].cs);
            check($sformatf("v%0d_we_cycles", i), we_n, vecs[i].we);
            check($sformatf("v%0d_re_cycles", i), re_n, vecs[i].re);
            if (vecs[i].we != 0) begin
                check($sformatf("v%0d_bus_addr", i), {24'h0, last_wr_addr}, {24'h0, vecs[i].a});
                check($sformatf("v%0d_bus_wdata", i), last_wr_data, vecs[i].d);
            end
            @(posedge clk); #1;
        end

        // Back-to-back write then read, no idle cycle between
        apb_xfer(1'b1, 8'h14, 32'hA5A5A5A5, 40, lat, err, rd, cs_n, we_n, re_n);
        check("b2b_wr_latency", lat, 2);
        apb_xfer(1'b0, 8'h14, 32'h0, 40, lat, err, rd, cs_n, we_n, re_n);
        check("b2b_rd_latency", lat, 3);
        check("b2b_rd_prdata", rd, 32'hA5A5A5A5);
        check("b2b_rd_pslverr", {31'h0, err}, 32'h0);
        @(posedge clk); #1;

        // Read that never sees data_valid
        dv_block = 1'b1;
        apb_xfer(1'b0, 8'h20, 32'h0, 100, lat, err, rd, cs_n, we_n, re_n);
`ifdef BRIDGE_TIMEOUT_EN
        check("to_latency", lat, 17);
        check("to_re_cycles", re_n, 16);
        check("to_pslverr", {31'h0, err}, 32'h1);
        check("to_prdata", rd, 32'h0);
`else
        check("to_no_pready", lat, -1);
        check("to_read_en_held", {31'h0, read_en}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
        dv_block = 1'b0;
        @(posedge clk); #1;

        // Reset during RD cycle 1
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("rstmid_read_en_before", {31'h0, read_en}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("rstmid_strobes", {30'h0, chip_select, read_en}, 32'h0);
        check("rstmid_pready", {31'h0, pready}, 32'h0);
        @(posedge clk); #1;
        apb_xfer(1'b0, 8'h10, 32'h0, 40, lat, err, rd, cs_n, we_n, re_n);
        check("rstmid_next_latency", lat, 3);
        check("rstmid_next_prdata", rd, 32'h00000001);

        check("strobe_protocol", bad_strobe, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_regbus_bridge.md
Name: apb_regbus_bridge

Overview:
- APB3 slave to custom register-bus master; sits directly upstream of the generated register files (addr/chip_select/write_en/read_en/write_data in, read_data/data_valid out).
- Converts one APB transfer into exactly one register-bus access and waits for the register file's registered data_valid.
- Rejects misaligned addresses and, optionally, times out reads that never see data_valid.

Parameters:
- ADDR_WIDTH, 8, width of paddr and addr.
- DATA_WIDTH, 32, width of pwdata/prdata/write_data/read_data.
- TIMEOUT_CYCLES, 16, maximum RD-state cycles before error; legal range ≥2. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  sole clock; all logic is posedge.
- rst  in  1  synchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data.
- pslverr  out  1  error response.
- addr  out  ADDR_WIDTH  register-bus address.
- chip_select  out  1  register-bus select.
- write_en  out  1  write strobe.
- read_en  out  1  read strobe.
- write_data  out  DATA_WIDTH  register-bus write data.
- read_data  in  DATA_WIDTH  register-bus read data; valid only while chip_select&read_en.
- data_valid  in  1  high the cycle after a read strobe.

Behaviour:
- Reset: all outputs are 0 after the first clk edge with rst=1. State is IDLE and the counter is 0. Reset mid-transfer abandons it and drops the strobes at that same edge.
- FSM states: IDLE, WR, RD, DONE. Bus outputs decode from the state flop and capture flops only; no combinational path from APB inputs.
- IDLE:
  - Setup phase (psel=1, penable=0) captures paddr→addr and pwdata→write_data.
  - paddr[1:0]≠0: err=1, go to DONE; no bus access.
  - Otherwise pwrite=1 → WR; pwrite=0 → RD.
- WR, exactly one cycle: chip_select=1, write_en=1, then DONE.
- RD: chip_select=1, read_en=1, counter increments each cycle.
  - data_valid=1: read_data captured into prdata at that edge, then DONE. The strobes remain high during the data_valid cycle, so read_data is still driven by the register file.
  - data_valid never returns: see Optional Feature.
- DONE, one cycle: pready=1 and pslverr=err; then IDLE, clearing err and the counter.
- Latency, setup edge to pready-high cycle:
  - write: 2 cycles (1 wait state);
  - read: 3 cycles (2 wait states) against the standard register file;
  - misaligned: 1 cycle.
- prdata holds its last captured value until the next read completes. Writes and errors do not update it, except a timeout, which forces prdata to 0.
- Back-to-back: a new setup phase is accepted in IDLE the cycle after DONE, giving no dead cycle beyond APB's own.
- If psel drops while in WR/RD, the bridge finishes the bus access and passes through DONE; pready then pulses harmlessly.
- write_en and read_en are never high together. chip_select=1 only in WR/RD.

Optional Feature:
- BRIDGE_TIMEOUT_EN defined:
  - If the counter reaches TIMEOUT_CYCLES in RD without data_valid: err=1, prdata=0, go to DONE.
  - The strobes drop in DONE.
- Not defined:
  - No counter logic; RD waits indefinitely for data_valid.
  - pslverr is raised only for misalignment.

Decomposition:
- Package apb_regbus_pkg holds:
  - the state enum (IDLE/WR/RD/DONE);
  - the default ADDR_WIDTH/DATA_WIDTH;
  - the ALIGN_MASK constant (2'b11).
- One sub-module, regbus_timeout_cnt: clear, enable, expired output, parameterised on TIMEOUT_CYCLES.
- Everything else stays flat in the bridge.

Test Plan:
- APB write paddr=0x10, pwdata=0x00000001 → single cycle chip_select=write_en=1 with addr=0x10, write_data=1; pready 2 cycles after setup; pslverr=0.
- APB read paddr=0x14 against a register-file model holding 0xDEADBEEF → read_en high 2 cycles; prdata=0xDEADBEEF with pready on the 3rd cycle; pslverr=0.
- APB write paddr=0x13 → no chip_select; pready+pslverr=1 on the cycle after setup; a subsequent read returns the previous prdata unchanged.
- BRIDGE_TIMEOUT_EN, data_valid tied 0, read 0x20 → read_en high exactly 16 cycles; then pready=1, pslverr=1, prdata=0. Without the macro → no pready after 100 cycles.
- Back-to-back write 0x14=0xA5A5A5A5 then read 0x14 → read returns 0xA5A5A5A5; strobes never overlap.
- rst=1 asserted during RD cycle 1 → next cycle chip_select=read_en=pready=0, state IDLE; the next read completes normally.
